// File: rtl/misr_pkg.sv
// Shared definitions for the multi-lane MISR peripheral: register offsets,
// CONTROL bit positions and the sequencer state encoding.
package misr_pkg;

    // Byte offsets from the peripheral base address
    localparam int unsigned OffControl   = 32'h000;
    localparam int unsigned OffCoeff     = 32'h040;
    localparam int unsigned OffSignature = 32'h080;
    localparam int unsigned OffDone      = 32'h0C0;
    localparam int unsigned OffLength    = 32'h100;
    localparam int unsigned OffSeed      = 32'h140;

    // CONTROL register fields
    localparam int unsigned CtrlEnBit  = 0;
    localparam int unsigned CtrlClrBit = 1;
    localparam int unsigned CtrlSelLsb = 8;
    localparam int unsigned CtrlSelW   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } misr_state_e;

endpackage

// File: rtl/misr_lane.sv
// One MISR signature lane: load wins over step; step shifts left, folds the
// feedback polynomial in when the MSB falls out, and XORs in new data.
module misr_lane
    import misr_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         step_i,
    input  logic         load_i,
    input  logic [W-1:0] seed_i,
    input  logic [W-1:0] coeff_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o
);

    logic [W-1:0] sig_q, sig_d;

    // Next signature: reload from seed, compact one word, or hold
    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = seed_i;
        end else if (step_i) begin
            sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? coeff_i : '0) ^ data_i;
        end
    end

    // Signature register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/misr_multi_periph.sv
// Bus-mapped multi-lane MISR. A CONTROL write starts a run of LENGTH cycles
// during which each lane compacts its data whenever its strobe is high.
// Define MISR_SEED_EN to add a SEED register that clear loads into every lane.
module misr_multi_periph
    import misr_pkg::*;
#(
    parameter int unsigned NBIT_DATA  = 64,
    parameter int unsigned NBIT_ADDR  = 64,
    parameter int unsigned START_ADDR = 2**25,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned NBIT_LEN   = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_i,
    input  logic                            we_i,
    input  logic [NBIT_ADDR-1:0]            addr_i,
    input  logic [NBIT_DATA-1:0]            data_i,
    output logic [NBIT_DATA-1:0]            data_o,
    input  logic [N_CH-1:0][NBIT_DATA-1:0]  ch_data_i,
    input  logic [N_CH-1:0]                 ch_valid_i,
    output logic                            done_o
);

    misr_state_e          state_q, state_d;
    logic [NBIT_LEN-1:0]  cnt_q, cnt_d;
    logic [NBIT_LEN-1:0]  len_q, len_d;
    logic [NBIT_DATA-1:0] coeff_q, coeff_d;
    logic [NBIT_DATA-1:0] rdata_q, rdata_d;
    logic [CtrlSelW-1:0]  sel_q, sel_d;
    logic                 en_q, en_d;
    logic                 done_q, done_d;

    logic [NBIT_ADDR-1:0] offset;
    logic                 wr, rd;
    logic                 hit_ctrl, hit_coeff, hit_sig, hit_done, hit_len;
    logic                 wr_ctrl, ctrl_clr, ctrl_en, terminal;
    logic                 load, step;
    logic [NBIT_DATA-1:0] seed_val;
    logic [NBIT_DATA-1:0] rdata;
    logic [NBIT_DATA-1:0] sig [N_CH];

    // Addresses below the base wrap to large offsets and fall out as unmapped
    assign offset    = addr_i - NBIT_ADDR'(START_ADDR);
    assign wr        = req_i & we_i;
    assign rd        = req_i & ~we_i;
    assign hit_ctrl  = (offset == NBIT_ADDR'(OffControl));
    assign hit_coeff = (offset == NBIT_ADDR'(OffCoeff));
    assign hit_sig   = (offset == NBIT_ADDR'(OffSignature));
    assign hit_done  = (offset == NBIT_ADDR'(OffDone));
    assign hit_len   = (offset == NBIT_ADDR'(OffLength));
    assign wr_ctrl   = wr & hit_ctrl;
    assign ctrl_clr  = wr_ctrl & data_i[CtrlClrBit];
    assign ctrl_en   = wr_ctrl & data_i[CtrlEnBit];
    assign terminal  = (cnt_q == len_q - NBIT_LEN'(1));

`ifdef MISR_SEED_EN
    logic                 hit_seed;
    logic [NBIT_DATA-1:0] seed_q, seed_d;

    assign hit_seed = (offset == NBIT_ADDR'(OffSeed));
    assign seed_d   = (wr && hit_seed) ? data_i : seed_q;
    assign seed_val = seed_q;

    // Seed register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seed_q <= '0;
        end else begin
            seed_q <= seed_d;
        end
    end
`else
    assign seed_val = '0;
`endif

    // Sequencer next state and register-file writes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        coeff_d = coeff_q;
        sel_d   = sel_q;
        en_d    = en_q;
        done_d  = done_q;
        load    = 1'b0;
        step    = 1'b0;

        if (wr_ctrl) begin
            sel_d = data_i[CtrlSelLsb +: CtrlSelW];
            en_d  = data_i[CtrlEnBit];
        end
        if (wr && hit_coeff && state_q != StRun) begin
            coeff_d = data_i;
        end
        if (wr && hit_len && state_q != StRun) begin
            len_d = data_i[NBIT_LEN-1:0];
        end

        if (ctrl_clr) begin
            load    = 1'b1;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = StIdle;
        end

        // A bus CONTROL write that affects the FSM overrides the run step
        if (ctrl_en && (ctrl_clr || state_q != StRun)) begin
            cnt_d = '0;
            if (len_q == '0) begin
                state_d = StDone;
                done_d  = 1'b1;
                en_d    = 1'b0;
            end else begin
                state_d = StRun;
                done_d  = 1'b0;
            end
        end else if (wr_ctrl && !ctrl_clr && !data_i[CtrlEnBit] && state_q == StRun) begin
            state_d = StIdle;
        end else if (state_q == StRun && !ctrl_clr) begin
            step  = 1'b1;
            cnt_d = cnt_q + NBIT_LEN'(1);
            if (terminal) begin
                state_d = StDone;
                done_d  = 1'b1;
                en_d    = 1'b0;
            end
        end
    end

    // Read mux; unmapped offsets and out-of-range lane selects read as zero
    always_comb begin
        rdata = '0;
        if (hit_ctrl) begin
            rdata[CtrlEnBit]                 = en_q;
            rdata[CtrlSelLsb +: CtrlSelW]    = sel_q;
        end else if (hit_coeff) begin
            rdata = coeff_q;
        end else if (hit_sig) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (sel_q == CtrlSelW'(k)) begin
                    rdata = sig[k];
                end
            end
        end else if (hit_done) begin
            rdata[0] = done_q;
        end else if (hit_len) begin
            rdata = NBIT_DATA'(len_q);
`ifdef MISR_SEED_EN
        end else if (hit_seed) begin
            rdata = seed_q;
`endif
        end
    end

    assign rdata_d = rd ? rdata : rdata_q;

    // Control, status and read-data registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            coeff_q <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            coeff_q <= coeff_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        misr_lane #(
            .W(NBIT_DATA)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .step_i (step & ch_valid_i[k]),
            .load_i (load),
            .seed_i (seed_val),
            .coeff_i(coeff_q),
            .data_i (ch_data_i[k]),
            .sig_o  (sig[k])
        );
    end

    assign data_o = rdata_q;
    assign done_o = done_q;

endmodule
